// File: rtl/uart_mutex_pkg.sv
// Shared encodings for the UART mutex op-word bus and the node requester state type.
package uart_mutex_pkg;
  localparam logic [3:0]  FUNC_TAG    = 4'hB;
  localparam logic [15:0] START_BASE  = {4'hF, FUNC_TAG, 8'hFF};
  localparam logic [15:0] STOP_WORD   = {4'hF, FUNC_TAG, 8'h00};
  localparam logic [7:0]  DATA_PREFIX = 8'h01;
  // Sense is a data word carrying the UART NOP byte.
  localparam logic [15:0] SENSE_WORD  = {DATA_PREFIX, 8'h00};

  localparam logic [7:0]  LOCK_FREE   = 8'h00;
  localparam logic [7:0]  LOCK_NODE0  = 8'h01;
  localparam logic [7:0]  LOCK_NODE1  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ_S, ST_REQ_P, ST_REQ_C, ST_SEND, ST_GAP, ST_STOP
  } req_state_e;

  function automatic logic [15:0] start_word(input logic [3:0] prio);
    return START_BASE ^ {12'h000, prio};
  endfunction

  function automatic logic [15:0] data_word(input logic [7:0] b);
    return {DATA_PREFIX, b};
  endfunction
endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; push when full / pop when empty are ignored.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_node_requester.sv
// Per-node requester: buffers node bytes, wins the UART mutex with START/SENSE probes,
// streams the frame as DATA words and releases with STOP.
module uart_node_requester
  import uart_mutex_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     go,
  input  logic [LEN_W-1:0]         go_len,
  input  logic [3:0]               go_prio,
  input  logic                     tx_ready,
  input  logic [15:0]              grant_bus,
  output logic [15:0]              op_word,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] OWN_ID = 8'(NODE_ID + 1);

  req_state_e       state_q, state_d;
  logic [15:0]      op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       prio_q, prio_d;
  logic [RW-1:0]    rounds_q, rounds_d;
  logic             snd_q, snd_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;

  logic       fifo_full, fifo_empty, pop, granted, emit;
  logic [7:0] head;
  logic       unused_periph;

  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (wr_valid),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign wr_ready      = ~fifo_full;
  assign granted       = (grant_bus[15:8] == OWN_ID);
  assign unused_periph = ^grant_bus[7:0];
  assign emit          = tx_ready & ~fifo_empty;

  // op_d is the word for the state being entered, so the bus shows each state's word
  // during that state; a DATA word is therefore committed one cycle before its pop.
  always_comb begin
    state_d  = state_q;
    op_d     = 16'h0000;
    len_d    = len_q;
    prio_d   = prio_q;
    rounds_d = rounds_q;
    snd_d    = 1'b0;
    done_d   = 1'b0;
    terr_d   = terr_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go && go_len != '0 && go_prio != 4'h0) begin
          state_d  = ST_REQ_S;
          op_d     = start_word(go_prio);
          len_d    = go_len;
          prio_d   = go_prio;
          rounds_d = '0;
          terr_d   = 1'b0;
        end
      end
      ST_REQ_S: begin
        state_d = ST_REQ_P;
        op_d    = SENSE_WORD;
      end
      ST_REQ_P: state_d = ST_REQ_C;
      ST_REQ_C: begin
        if (granted) begin
          state_d = ST_SEND;
          if (emit) begin
            op_d  = data_word(head);
            snd_d = 1'b1;
          end
        end else begin
          rounds_d = rounds_q + RW'(1);
          if (rounds_d == RW'(TIMEOUT)) begin
            state_d = ST_STOP;
            op_d    = STOP_WORD;
            terr_d  = 1'b1;
          end else begin
            state_d = ST_REQ_S;
            op_d    = start_word(prio_q);
          end
        end
      end
      ST_SEND: begin
        if (snd_q) begin
          pop     = 1'b1;
          len_d   = len_q - LEN_W'(1);
          state_d = ST_GAP;
        end else if (emit) begin
          op_d  = data_word(head);
          snd_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (len_q == '0) begin
          state_d = ST_STOP;
          op_d    = STOP_WORD;
        end else begin
          state_d = ST_SEND;
          if (emit) begin
            op_d  = data_word(head);
            snd_d = 1'b1;
          end
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        done_d  = ~terr_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= 16'h0000;
      len_q    <= '0;
      prio_q   <= 4'h0;
      rounds_q <= '0;
      snd_q    <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      prio_q   <= prio_d;
      rounds_q <= rounds_d;
      snd_q    <= snd_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
    end
  end

  assign op_word     = op_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_uart_node_requester.sv
// Directed bench for uart_node_requester: a per-cycle vector table for the basic frame,
// then hand-written sequences for contention, timeout, stall, FIFO full and reset.
module tb_uart_node_requester;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  go_len = '0;
  logic [3:0]  go_prio = '0;
  logic        tx_ready = 1'b0;
  logic [15:0] grant_bus = '0;
  logic [15:0] grant_none = '0;

  logic        wr_ready, busy, done, timeout_err;
  logic [15:0] op_word;
  logic [4:0]  fifo_count;
  logic        wr_ready_t, busy_t, done_t, timeout_err_t;
  logic [15:0] op_word_t;
  logic [4:0]  fifo_count_t;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_node_requester #(.NODE_ID(0), .DEPTH(16), .LEN_W(8), .TIMEOUT(1023)) dut (
    .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .go(go), .go_len(go_len), .go_prio(go_prio), .tx_ready(tx_ready), .grant_bus(grant_bus),
    .op_word(op_word), .busy(busy), .done(done), .timeout_err(timeout_err),
    .fifo_count(fifo_count)
  );

  // Short-timeout instance that is never granted.
  uart_node_requester #(.NODE_ID(0), .DEPTH(16), .LEN_W(8), .TIMEOUT(3)) dut_to (
    .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready_t),
    .go(go), .go_len(go_len), .go_prio(go_prio), .tx_ready(tx_ready), .grant_bus(grant_none),
    .op_word(op_word_t), .busy(busy_t), .done(done_t), .timeout_err(timeout_err_t),
    .fifo_count(fifo_count_t)
  );

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        g;
    logic [7:0]  len;
    logic [3:0]  prio;
    logic        tx;
    logic [15:0] gnt;
    logic [15:0] op;
    logic        bsy;
    logic        dn;
    logic [4:0]  cnt;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic g,
                              input logic [7:0] len, input logic [3:0] prio, input logic tx,
                              input logic [15:0] gnt, input logic [15:0] op, input logic bsy,
                              input logic dn, input logic [4:0] cnt);
    vec_t v;
    v.wv = wv; v.wd = wd; v.g = g; v.len = len; v.prio = prio; v.tx = tx; v.gnt = gnt;
    v.op = op; v.bsy = bsy; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wr_valid = 1'b0; wr_data = '0; go = 1'b0; go_len = '0; go_prio = '0;
    tx_ready = 1'b0; grant_bus = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  vec_t        tv[15];
  logic [15:0] exp_to[11];
  logic [15:0] q[$];
  logic [15:0] exp_q[$];
  int          starts, senses, data_seen, dones;

  initial begin
    // Frame of 41,42,43, granted on first probe.
    tv[0]  = mk(1, 8'h41, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    tv[1]  = mk(1, 8'h42, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 2);
    tv[2]  = mk(1, 8'h43, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 3);
    tv[3]  = mk(0, 8'h00, 1, 3, 5, 1, 16'h0000, 16'hFBFA, 1, 0, 3);
    tv[4]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h0000, 16'h0100, 1, 0, 3);
    tv[5]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 3);
    tv[6]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0141, 1, 0, 3);
    tv[7]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0000, 1, 0, 2);
    tv[8]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0142, 1, 0, 2);
    tv[9]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0000, 1, 0, 1);
    tv[10] = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0143, 1, 0, 1);
    tv[11] = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0000, 1, 0, 0);
    tv[12] = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'hFB00, 1, 0, 0);
    tv[13] = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0000, 0, 1, 0);
    tv[14] = mk(0, 8'h00, 0, 0, 0, 1, 16'h0100, 16'h0000, 0, 0, 0);

    exp_to = '{16'hFBF0, 16'h0100, 16'h0000, 16'hFBF0, 16'h0100, 16'h0000,
               16'hFBF0, 16'h0100, 16'h0000, 16'hFB00, 16'h0000};

    // Reset state
    do_reset();
    chk("rst_op", op_word, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // 1: table-driven basic frame
    for (int i = 0; i < 15; i++) begin
      wr_valid = tv[i].wv; wr_data = tv[i].wd; go = tv[i].g; go_len = tv[i].len;
      go_prio = tv[i].prio; tx_ready = tv[i].tx; grant_bus = tv[i].gnt;
      tick();
      chk($sformatf("t1_op[%0d]", i), op_word, tv[i].op);
      chk($sformatf("t1_busy[%0d]", i), busy, tv[i].bsy);
      chk($sformatf("t1_done[%0d]", i), done, tv[i].dn);
      chk($sformatf("t1_cnt[%0d]", i), fifo_count, tv[i].cnt);
    end

    // 2: other node owns the mutex for 4 rounds
    do_reset();
    wr_valid = 1; wr_data = 8'h55; tick(); wr_valid = 0;
    go = 1; go_len = 1; go_prio = 1; tx_ready = 1; grant_bus = 16'h0200;
    starts = 0; senses = 0; data_seen = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) go = 0;
      if (op_word == 16'hFBFE) starts++;
      if (op_word == 16'h0100) senses++;
      if (op_word == 16'h0155) data_seen++;
      if (done) dones++;
      grant_bus = (starts >= 5) ? 16'h0100 : 16'h0200;
    end
    chk("t2_starts", starts, 5);
    chk("t2_senses", senses, 5);
    chk("t2_data", data_seen, 1);
    chk("t2_done", dones, 1);
    chk("t2_terr", timeout_err, 0);

    // 3: TIMEOUT=3, never granted
    do_reset();
    go = 1; go_len = 1; go_prio = 15;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) go = 0;
      chk($sformatf("t3_op[%0d]", i), op_word_t, exp_to[i]);
      if (i == 9) begin
        chk("t3_terr_stop", timeout_err_t, 1);
        chk("t3_busy_stop", busy_t, 1);
      end
      if (i == 10) begin
        chk("t3_busy_after", busy_t, 0);
        chk("t3_terr_after", timeout_err_t, 1);
      end
      chk($sformatf("t3_nodone[%0d]", i), done_t, 0);
    end
    go = 1; go_len = 1; go_prio = 15;
    tick(); go = 0;
    chk("t3_terr_clear", timeout_err_t, 0);

    // 4: FIFO runs dry mid-frame, rest pushed later
    do_reset();
    wr_valid = 1; wr_data = 8'hA1; tick(); wr_data = 8'hA2; tick(); wr_valid = 0;
    go = 1; go_len = 4; go_prio = 3; tx_ready = 1; grant_bus = 16'h0100;
    q.delete(); dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) go = 0;
      if (op_word != 16'h0000) q.push_back(op_word);
      if (done) dones++;
      if (i == 9) begin
        chk("t4_stall_op", op_word, 16'h0000);
        chk("t4_stall_busy", busy, 1);
        wr_valid = 1; wr_data = 8'hA3;
      end else if (i == 10) begin
        wr_data = 8'hA4;
      end else begin
        wr_valid = 0;
      end
    end
    exp_q = '{16'hFBFC, 16'h0100, 16'h01A1, 16'h01A2, 16'h01A3, 16'h01A4, 16'hFB00};
    chk("t4_nwords", q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      chk($sformatf("t4_word[%0d]", i), q[i], exp_q[i]);
    chk("t4_done", dones, 1);

    // 5: fill to DEPTH, drop overflow, push+pop in SEND keeps count
    do_reset();
    wr_valid = 1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'h10 + i);
      tick();
    end
    chk("t5_full_cnt", fifo_count, 16);
    chk("t5_full_ready", wr_ready, 0);
    wr_data = 8'hEE; tick(); wr_valid = 0;
    chk("t5_drop_cnt", fifo_count, 16);
    go = 1; go_len = 16; go_prio = 2; tx_ready = 1; grant_bus = 16'h0100;
    q.delete();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 0) go = 0;
      if (op_word != 16'h0000) q.push_back(op_word);
      if (i == 4) chk("t5_pop_cnt", fifo_count, 15);
      if (i == 5) begin
        wr_valid = 1; wr_data = 8'h77;
      end else begin
        wr_valid = 0;
      end
      if (i == 6) chk("t5_pushpop_cnt", fifo_count, 15);
    end
    exp_q.delete();
    exp_q.push_back(16'hFBFD);
    exp_q.push_back(16'h0100);
    for (int i = 0; i < 16; i++) exp_q.push_back(16'(16'h0110 + i));
    exp_q.push_back(16'hFB00);
    chk("t5_nwords", q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      chk($sformatf("t5_word[%0d]", i), q[i], exp_q[i]);
    chk("t5_left_cnt", fifo_count, 1);

    // 6: async reset mid-SEND, then ignored go requests
    do_reset();
    wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h30 + i);
      tick();
    end
    wr_valid = 0;
    go = 1; go_len = 3; go_prio = 4; tx_ready = 1; grant_bus = 16'h0100;
    tick(); go = 0;
    tick(); tick(); tick();
    chk("t6_pre_op", op_word, 16'h0130);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_op", op_word, 16'h0000);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", fifo_count, 0);
    tick(); RST = 1'b0;
    go = 1; go_len = 3; go_prio = 0;
    tick();
    chk("t6_prio0_busy", busy, 0);
    chk("t6_prio0_op", op_word, 16'h0000);
    go_len = 0; go_prio = 5;
    tick();
    chk("t6_len0_busy", busy, 0);
    go = 0;
    tick();
    chk("t6_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
